pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Parametrised N-bit adder/subtractor, split into STAGES carry-chained pipeline chunks.
//   Generalises the 1-bit full adder to WIDTH bits, adds a subtract mode, and adds a
//   valid/ready stream interface with backpressure. Feeds the datapath ALU and the PC/branch adders.
// PARAMETERS
//   WIDTH   32  operand/result width in bits
//   STAGES  4   pipeline depth, >=1; WIDTH % STAGES must be 0 (elaboration error otherwise)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts operand beat this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   Cin        in   1      carry-in (borrow-in when Sub=1)
//   Sub        in   1      0: S=A+B+Cin; 1: S=A-B-Cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result this cycle
//   S          out  WIDTH  sum/difference
//   Cout       out  1      carry-out (Sub=1: inverted borrow, 1 = no borrow)
//   Ovf        out  1      signed overflow (only with ADDER_FLAGS_EN)
//   Zero       out  1      S==0 (only with ADDER_FLAGS_EN)
// BEHAVIOUR
//   - Chunk width CW=WIDTH/STAGES. Stage k adds bits [k*CW +: CW] using the registered carry of stage k-1.
//   - Upper operand chunks are skewed (delayed k cycles); lower result chunks are deskewed, so S is coherent.
//   - Sub=1: B chunks inverted, effective carry-in = ~Cin, so S=A+~B+~Cin = A-B-Cin mod 2^WIDTH.
//   - Latency: exactly STAGES cycles from accepted beat (in_valid&&in_ready) to out_valid, when not stalled.
//   - Throughput: one beat per cycle; order preserved; per-stage valid bit, so bubbles propagate.
//   - Stall: en = !out_valid || out_ready; all stage regs and valid bits advance only when en=1.
//     in_ready = en (combinational). The whole pipeline freezes on a stall, with no internal bubble collapse.
//   - Output hold: while out_valid && !out_ready, S/Cout/flags are held stable.
//   - in_valid=0 while en=1 inserts a bubble. Data inputs are don't-care when in_valid=0.
//   - Reset (rst_n=0, async): all valid bits=0; out_valid=0; S=0; Cout=0; Ovf=0; Zero=0.
//     in_ready=1 immediately after release. In-flight beats are discarded, never emitted.
//   - Wrap-around: S is modulo 2^WIDTH; the carry out of the MSB chunk drives Cout.
//   - STAGES=1: a single registered WIDTH-bit adder with latency 1.
// CONFIGURATION
//   ADDER_FLAGS_EN defined:
//     Ovf = (A[MSB]==B'[MSB]) && (S[MSB]!=A[MSB]), where B' = B after Sub inversion.
//     Zero = ~|S. Both are registered with the final stage, aligned to out_valid, and reset to 0.
//   ADDER_FLAGS_EN undefined: the Ovf and Zero ports and their logic are absent.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//   1. Hold rst_n=0, then release -> out_valid=0, S=8'h00, Cout=0, in_ready=1, with no spurious output.
//   2. A=8'hFF, B=8'h01, Cin=0, Sub=0 -> 2 cycles later out_valid=1, S=8'h00, Cout=1 (carry crosses chunk).
//   3. Stream i=0..255 back-to-back with A=i, B=i, Cin=i[0], out_ready=1
//      -> S=(2i+i[0])&8'hFF, one result per cycle, in order.
//   4. Sub=1: A=8'h05, B=8'h07, Cin=0 -> S=8'hFE, Cout=0.
//      A=8'h80, B=8'h01 -> S=8'h7F, Cout=1; with ADDER_FLAGS_EN, Ovf=1, Zero=0.
//   5. Fill pipeline, then out_ready=0 for 5 cycles -> in_ready=0, S stable, no loss or duplication;
//      release -> remaining beats emitted in order.
//   6. WIDTH=4, STAGES=4, all 512 {A,B,Cin} combos at Sub=0 vs. reference model -> all match.
//      Then rst_n=0 with 3 beats in flight -> out_valid=0 at once, none emitted after release.

Source files
------------

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor split into STAGES carry-chained chunks behind a valid/ready stream.
// Define ADDER_FLAGS_EN to add the registered signed-overflow (Ovf) and zero (Zero) outputs.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef ADDER_FLAGS_EN
    ,
    output logic             Ovf,
    output logic             Zero
`endif
);

    localparam int unsigned STAGES_NZ = (STAGES == 0) ? 1 : STAGES;
    localparam int unsigned CW        = WIDTH / STAGES_NZ;

    if ((STAGES == 0) || ((WIDTH % STAGES_NZ) != 0)) begin : g_bad_params
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // The whole pipe advances together; a stalled output freezes every stage.
    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign w_b_eff   = Sub ? ~B : B;
    assign w_cin_eff = Sub ? ~Cin : Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned AW = WIDTH - k * CW;
        localparam int unsigned LW = (k + 1) * CW;

        // w_*_rest: operand bits not yet consumed; the low CW bits are this stage's chunk.
        logic [AW-1:0] w_a_rest;
        logic [AW-1:0] w_b_rest;
        logic          w_cin;
        logic          w_valid_in;
        logic [CW:0]   w_chunk_sum;
        logic [LW-1:0] w_sum_next;

        logic          r_valid;
        logic          r_carry;
        logic [LW-1:0] r_sum;

        if (k == 0) begin : g_head
            assign w_a_rest   = A;
            assign w_b_rest   = w_b_eff;
            assign w_cin      = w_cin_eff;
            assign w_valid_in = in_valid;
            assign w_sum_next = w_chunk_sum[CW-1:0];
        end else begin : g_tail
            assign w_a_rest   = g_stage[k-1].g_skew.r_a;
            assign w_b_rest   = g_stage[k-1].g_skew.r_b;
            assign w_cin      = g_stage[k-1].r_carry;
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_sum_next = {w_chunk_sum[CW-1:0], g_stage[k-1].r_sum};
        end

        assign w_chunk_sum = {1'b0, w_a_rest[CW-1:0]}
                           + {1'b0, w_b_rest[CW-1:0]}
                           + (CW+1)'(w_cin);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_valid_in;
                r_carry <= w_chunk_sum[CW];
                r_sum   <= w_sum_next;
            end
        end

        // Skew: carry the upper operand chunks forward to the stage that consumes them.
        if (k < STAGES - 1) begin : g_skew
            logic [AW-CW-1:0] r_a;
            logic [AW-CW-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_rest[AW-1:CW];
                    r_b <= w_b_rest[AW-1:CW];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign S         = g_stage[STAGES-1].r_sum;
    assign Cout      = g_stage[STAGES-1].r_carry;

`ifdef ADDER_FLAGS_EN
    logic w_a_msb;
    logic w_b_msb;
    logic w_s_msb;
    logic r_ovf;
    logic r_zero;

    assign w_a_msb = g_stage[STAGES-1].w_a_rest[CW-1];
    assign w_b_msb = g_stage[STAGES-1].w_b_rest[CW-1];
    assign w_s_msb = g_stage[STAGES-1].w_chunk_sum[CW-1];

    // Flags are formed from the final chunk so they land with the coherent result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            r_ovf  <= (w_a_msb == w_b_msb) && (w_s_msb != w_a_msb);
            r_zero <= ~|g_stage[STAGES-1].w_sum_next;
        end
    end

    assign Ovf  = r_ovf;
    assign Zero = r_zero;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench: 8-bit/2-stage and 4-bit/4-stage instances of pipelined_adder.
module tb_pipelined_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       v8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0, ordy8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       r8, ov8, cout8;
    logic [7:0] s8;

    logic       v4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0, ordy4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       r4, ov4, cout4;
    logic [3:0] s4;
`ifdef ADDER_FLAGS_EN
    logic ovf8, zero8, ovf4, zero4;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .A(a8), .B(b8), .Cin(cin8), .Sub(sub8),
        .out_valid(ov8), .out_ready(ordy8), .S(s8), .Cout(cout8)
`ifdef ADDER_FLAGS_EN
        , .Ovf(ovf8), .Zero(zero8)
`endif
    );

    pipelined_adder #(.WIDTH(4), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
        .out_valid(ov4), .out_ready(ordy4), .S(s4), .Cout(cout4)
`ifdef ADDER_FLAGS_EN
        , .Ovf(ovf4), .Zero(zero4)
`endif
    );

    task automatic test_reset();
        logic bad;
        v8 = 1'b0; ordy8 = 1'b0; v4 = 1'b0; ordy4 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ov8, cout8, s8} !== 10'h000 || {ov4, cout4, s4} !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got ov8=%b cout8=%b S8=%h ov4=%b S4=%h, want all 0",
                     ov8, cout8, s8, ov4, s4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (r8 !== 1'b1 || ov8 !== 1'b0 || r4 !== 1'b1 || ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b/%b out_valid=%b/%b, want 1/1 0/0",
                     r8, r4, ov8, ov4);
        end
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ov8 !== 1'b0 || ov4 !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_spurious: got out_valid=1 after release, want 0");
        end
    endtask

    // Single beats; result must appear exactly two cycles after acceptance.
    task automatic test_carry_chain();
        logic [7:0] va [2] = '{8'hFF, 8'h0F};
        logic [7:0] vb [2] = '{8'h01, 8'h00};
        logic       vc [2] = '{1'b0, 1'b1};
        logic [9:0] ve [2] = '{{1'b1, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h10}};
        ordy8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            v8 = 1'b1; a8 = va[i]; b8 = vb[i]; cin8 = vc[i]; sub8 = 1'b0;
            @(posedge clk); #1;
            v8 = 1'b0;
            n_checks++;
            if (ov8 !== 1'b0) begin
                n_fail++;
                $display("FAIL carry_latency_%0d: got out_valid=%b after 1 cycle, want 0", i, ov8);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov8, cout8, s8} !== ve[i]) begin
                n_fail++;
                $display("FAIL carry_result_%0d: got valid=%b cout=%b S=%h, want %b %b %h",
                         i, ov8, cout8, s8, ve[i][9], ve[i][8], ve[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q[$];
        logic [8:0] e;
        int idx = 0, n_out = 0, last_cyc = -1;
        ordy8 = 1'b1;
        for (int cyc = 0; cyc < 300 && n_out < 256; cyc++) begin
            @(posedge clk); #1;
            if (idx < 256) begin
                v8 = 1'b1; a8 = 8'(idx); b8 = 8'(idx); cin8 = 1'(idx & 1); sub8 = 1'b0;
            end else begin
                v8 = 1'b0;
            end
            #1;
            if (ov8) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_spurious: got out S=%h with nothing outstanding", s8);
                end else begin
                    e = q.pop_front();
                    if ({cout8, s8} !== e) begin
                        n_fail++;
                        $display("FAIL stream_%0d: got cout=%b S=%h, want %b %h",
                                 n_out, cout8, s8, e[8], e[7:0]);
                    end
                end
                n_out++;
                last_cyc = cyc;
            end
            if (v8 && r8) begin
                q.push_back(9'(2 * idx + (idx & 1)));
                idx++;
            end
        end
        v8 = 1'b0;
        n_checks++;
        if (n_out != 256 || last_cyc != 257) begin
            n_fail++;
            $display("FAIL stream_throughput: got %0d results ending cycle %0d, want 256 ending 257",
                     n_out, last_cyc);
        end
    endtask

    task automatic test_subtract();
        logic [7:0]  va [5] = '{8'h05, 8'h80, 8'h10, 8'h00, 8'h7F};
        logic [7:0]  vb [5] = '{8'h07, 8'h01, 8'h0F, 8'h00, 8'hFF};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // {cout, S} and {ovf, zero}
        logic [8:0]  ve [5] = '{9'h0FE, 9'h17F, 9'h100, 9'h0FF, 9'h080};
        logic [1:0]  vf [5] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
        ordy8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            v8 = 1'b1; a8 = va[i]; b8 = vb[i]; cin8 = vc[i]; sub8 = 1'b1;
            @(posedge clk); #1;
            v8 = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (ov8 !== 1'b1 || {cout8, s8} !== ve[i]) begin
                n_fail++;
                $display("FAIL sub_%0d: got valid=%b cout=%b S=%h, want 1 %b %h",
                         i, ov8, cout8, s8, ve[i][8], ve[i][7:0]);
            end
`ifdef ADDER_FLAGS_EN
            n_checks++;
            if ({ovf8, zero8} !== vf[i]) begin
                n_fail++;
                $display("FAIL sub_flags_%0d: got ovf=%b zero=%b, want %b %b",
                         i, ovf8, zero8, vf[i][1], vf[i][0]);
            end
`else
            if (vf[i] === 2'bxx) $display("unused flag vector");
`endif
        end
        sub8 = 1'b0;
    endtask

    task automatic test_stall();
        logic [8:0] q[$];
        logic [8:0] e, s_hold;
        int idx = 0, n_out = 0;
        s_hold = '0;
        for (int cyc = 0; cyc < 40 && n_out < 10; cyc++) begin
            @(posedge clk); #1;
            ordy8 = !(cyc >= 4 && cyc < 9);
            if (idx < 10) begin
                v8 = 1'b1; a8 = 8'(8'h30 + 9 * idx); b8 = 8'(8'hE0 + idx);
                cin8 = 1'((idx >> 1) & 1); sub8 = 1'b0;
            end else begin
                v8 = 1'b0;
            end
            #1;
            if (cyc >= 4 && cyc < 9) begin
                n_checks++;
                if (r8 !== 1'b0 || ov8 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_ready_c%0d: got in_ready=%b out_valid=%b, want 0 1",
                             cyc, r8, ov8);
                end
                if (cyc == 4) begin
                    s_hold = {cout8, s8};
                end else begin
                    n_checks++;
                    if ({cout8, s8} !== s_hold) begin
                        n_fail++;
                        $display("FAIL stall_hold_c%0d: got %h, want %h", cyc, {cout8, s8}, s_hold);
                    end
                end
            end
            if (ov8 && ordy8) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_spurious: got S=%h with nothing outstanding", s8);
                end else begin
                    e = q.pop_front();
                    if ({cout8, s8} !== e) begin
                        n_fail++;
                        $display("FAIL stall_order_%0d: got %h, want %h", n_out, {cout8, s8}, e);
                    end
                end
                n_out++;
            end
            if (v8 && r8) begin
                q.push_back(9'(int'(a8) + int'(b8) + int'(cin8)));
                idx++;
            end
        end
        v8 = 1'b0; ordy8 = 1'b1;
        n_checks++;
        if (n_out != 10 || q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, %0d left, want 10 and 0", n_out, q.size());
        end
    endtask

    task automatic test_wide_sweep();
        logic [6:0] q[$];
        logic [6:0] e;
        logic [4:0] sum;
        int idx = 0, n_out = 0, last_cyc = -1;
        ordy4 = 1'b1;
        for (int cyc = 0; cyc < 600 && n_out < 512; cyc++) begin
            @(posedge clk); #1;
            if (idx < 512) begin
                v4 = 1'b1; a4 = 4'(idx >> 5); b4 = 4'(idx >> 1); cin4 = 1'(idx & 1); sub4 = 1'b0;
            end else begin
                v4 = 1'b0;
            end
            #1;
            if (ov4) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep_spurious: got S=%h with nothing outstanding", s4);
                end else begin
                    e = q.pop_front();
                    if ({cout4, s4} !== e[4:0]) begin
                        n_fail++;
                        $display("FAIL sweep_%0d: got cout=%b S=%h, want %b %h",
                                 n_out, cout4, s4, e[4], e[3:0]);
                    end
`ifdef ADDER_FLAGS_EN
                    if ({ovf4, zero4} !== e[6:5]) begin
                        n_fail++;
                        $display("FAIL sweep_flags_%0d: got ovf=%b zero=%b, want %b %b",
                                 n_out, ovf4, zero4, e[6], e[5]);
                    end
`endif
                end
                n_out++;
                last_cyc = cyc;
            end
            if (v4 && r4) begin
                sum = 5'(int'(a4) + int'(b4) + int'(cin4));
                q.push_back({(a4[3] == b4[3]) && (sum[3] != a4[3]), sum[3:0] == 4'h0, sum});
                idx++;
            end
        end
        v4 = 1'b0;
        n_checks++;
        if (n_out != 512 || last_cyc != 515) begin
            n_fail++;
            $display("FAIL sweep_throughput: got %0d results ending cycle %0d, want 512 ending 515",
                     n_out, last_cyc);
        end
    endtask

    task automatic test_reset_inflight();
        logic bad;
        ordy4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            v4 = 1'b1; a4 = 4'(7 + i); b4 = 4'(9 - i); cin4 = 1'b0; sub4 = 1'b0;
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        #1;
        n_checks++;
        if (ov4 !== 1'b1 || r4 !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_setup: got out_valid=%b in_ready=%b, want 1 0", ov4, r4);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov4, cout4, s4} !== 6'h00) begin
            n_fail++;
            $display("FAIL inflight_reset: got valid=%b cout=%b S=%h, want 0 0 0", ov4, cout4, s4);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ordy4 = 1'b1;
        #1;
        n_checks++;
        if (r4 !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_ready: got in_ready=%b, want 1", r4);
        end
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov4 !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL inflight_discard: got a result after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_back_to_back();
        test_subtract();
        test_stall();
        test_wide_sweep();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
